// File: rtl/noc_loopback_pkg.sv
// noc_loopback shared types: header field widths and the src/dest swap.
// Header occupies the top HDR_W bits of a flit as {dest, class, src}.
package noc_loopback_pkg;

  localparam int DEST_W  = 5;
  localparam int CLASS_W = 3;
  localparam int SRC_W   = 5;
  localparam int HDR_W   = DEST_W + CLASS_W + SRC_W;

  typedef struct packed {
    logic [DEST_W-1:0]  dest;
    logic [CLASS_W-1:0] cls;
    logic [SRC_W-1:0]   src;
  } hdr_t;

  function automatic logic [HDR_W-1:0] swap_src_dest(
    input logic [HDR_W-1:0] flit_hdr
  );
    hdr_t h;
    hdr_t r;
    h      = flit_hdr;
    r      = h;
    r.dest = h.src;
    r.src  = h.dest;
    return r;
  endfunction

endpackage

// File: rtl/noc_loopback_if.sv
// Multi-channel NoC flit stream: per-channel flit/last/valid with ready back.
// master drives flits, slave returns ready.
interface noc_loopback_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
);

  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] flit;
  logic [CHANNELS-1:0]                 last;
  logic [CHANNELS-1:0]                 valid;
  logic [CHANNELS-1:0]                 ready;

  modport master (
    output flit,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  flit,
    input  last,
    input  valid,
    output ready
  );

endinterface

// File: rtl/noc_loopback_fifo.sv
// Per-channel FIFO: clk, rst, push/pop, din, head (zero when empty),
// full/empty from registered pointers only, so no pop-to-push path.
module noc_loopback_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // extra pointer bit tells full from empty when indices match
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign head = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/noc_loopback.sv
// Single-tile NoC loopback: buffers each channel, swaps header src/dest.
// Ports: clk, rst, in_if (from tile), out_if (to tile), pkt_count.
module noc_loopback
  import noc_loopback_pkg::*;
#(
  parameter int FLIT_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  noc_loopback_if.slave             in_if,
  noc_loopback_if.master            out_if,
  output logic [CHANNELS-1:0][15:0] pkt_count
);

  localparam int FW = FLIT_WIDTH;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          in_packet;
    logic [FW-1:0] hdr;
    logic [FW:0]   din;
    logic [FW:0]   head;
    logic [15:0]   cnt;

    assign hdr = {
      swap_src_dest(in_if.flit[c][FW-1 -: HDR_W]),
      in_if.flit[c][FW-HDR_W-1:0]
    };

    // only the first flit of a packet is a header
    assign din = {
      in_if.last[c],
      in_packet ? in_if.flit[c] : hdr
    };

    assign push = in_if.valid[c] && !full;
    assign pop  = out_if.ready[c] && !empty;

    // any accepted flit decides the next state:
    // last closes the packet, otherwise we are inside one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_packet <= 1'b0;
      end else if (push) begin
        in_packet <= !in_if.last[c];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (pop && head[FW]) begin
        cnt <= cnt + 16'd1;
      end
    end

    noc_loopback_fifo #(
      .WIDTH (FW + 1),
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty)
    );

    assign in_if.ready[c]  = !full;
    assign out_if.valid[c] = !empty;
    assign out_if.flit[c]  = head[FW-1:0];
    assign out_if.last[c]  = head[FW];
    assign pkt_count[c]    = cnt;
  end

endmodule
